// File: rtl/inverse_shifter.sv
// inverse_shifter: undoes an earlier power-of-two scaling of an operand.
// It shifts one bit per cycle, and it flags any 1 bit that is shifted out.
// The FSM runs IDLE -> SHIFT (0..2 cycles) -> DONE -> IDLE.
module inverse_shifter #(
    parameter int size = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [size-1:0] data,
    input  logic [1:0]      coefficient,
    output logic            busy,
    output logic            done,
    output logic [size-1:0] result,
    output logic            inexact
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [size-1:0] r_work;
    logic            r_inexact;
    logic [1:0]      r_count;
    logic            r_dir_left;
    logic            w_accept;
    logic [1:0]      w_load_count;
    logic            w_load_left;

    // A start request counts only in IDLE. In the busy states it has no effect.
    assign w_accept = (r_state == S_IDLE) && start;

    // Turn the forward scaling code into the inverse shift direction and amount.
    always_comb begin
        w_load_count = 2'd0;
        w_load_left  = 1'b0;
        case (coefficient)
            2'b00:   w_load_count = 2'd1;               // was x2  -> right 1
            2'b01:   w_load_count = 2'd2;               // was x4  -> right 2
            2'b10: begin                                // was /2  -> left 1
                w_load_count = 2'd1;
                w_load_left  = 1'b1;
            end
            default: w_load_count = 2'd0;               // unscaled -> no shift
        endcase
    end

    // State register. Reset returns the FSM to IDLE at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. A zero-length operation goes straight to DONE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_load_count == 2'd0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_count == 2'd1) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: load on accept, then shift one bit per SHIFT cycle and collect lost bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work     <= '0;
            r_inexact  <= 1'b0;
            r_count    <= 2'd0;
            r_dir_left <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_work     <= data;
                        r_inexact  <= 1'b0;
                        r_count    <= w_load_count;
                        r_dir_left <= w_load_left;
                    end
                end
                S_SHIFT: begin
                    if (r_dir_left) begin
                        r_work    <= {r_work[size-2:0], 1'b0};
                        r_inexact <= r_inexact | r_work[size-1];
                    end else begin
                        r_work    <= {1'b0, r_work[size-1:1]};
                        r_inexact <= r_inexact | r_work[0];
                    end
                    r_count <= r_count - 2'd1;
                end
                default: begin
                    // DONE: keep the final values so they can be read.
                end
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign result  = r_work;
    assign inexact = r_inexact;

endmodule

// File: tb/tb_inverse_shifter.sv
// Self-checking bench for inverse_shifter. It runs directed vectors, then random operations.
// Each one is compared against an arithmetic reference model.
module tb_inverse_shifter;

    localparam int W = 5;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] data;
    logic [1:0]   coefficient;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         inexact;

    int n_checks;
    int n_errors;

    logic [W-1:0] prev_res;
    logic         prev_inx;

    inverse_shifter #(.size(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .data        (data),
        .coefficient (coefficient),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .inexact     (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every comparison and report any mismatch.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the inverse scaling done with plain arithmetic.
    task automatic model(input logic [W-1:0] d, input logic [1:0] c,
                         output logic [W-1:0] r, output logic x, output int n);
        int dv;
        dv = int'(d);
        case (c)
            2'b00:   begin n = 1; r = W'(dv / 2); x = (dv % 2) != 0; end
            2'b01:   begin n = 2; r = W'(dv / 4); x = (dv % 4) != 0; end
            2'b10:   begin n = 1; r = W'((dv * 2) % (1 << W)); x = dv >= (1 << (W - 1)); end
            default: begin n = 0; r = d; x = 1'b0; end
        endcase
    endtask

    // Run one operation. It enters at a negedge and returns at the negedge of the done cycle.
    // noise: 0 = start low while busy, 1 = start held high, 2 = random start.
    // The data and coefficient inputs are scrambled after acceptance.
    task automatic do_op(input logic [W-1:0] d, input logic [1:0] c, input int noise);
        logic [W-1:0] er;
        logic         ex;
        int           n;
        int           cycles;
        model(d, c, er, ex, n);
        start = 1'b0;
        @(negedge clk);
        // This is the first IDLE cycle after the previous operation. Results must still hold.
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("hold_result", result, prev_res);
        check("hold_inexact", inexact, prev_inx);
        start = 1'b1;
        data = d;
        coefficient = c;
        cycles = 0;
        forever begin
            @(negedge clk);
            cycles++;
            start = (noise == 1) ? 1'b1 : (noise == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            data = W'($urandom);
            coefficient = 2'($urandom);
            if (done) break;
            check("busy_run", busy, 1);
            if (cycles >= 8) begin
                check("timeout_done", 0, 1);
                break;
            end
        end
        check("latency", cycles, n + 1);
        check("busy_done", busy, 1);
        check("result", result, er);
        check("inexact", inexact, ex);
        $display("op data=%b coef=%b result=%b inexact=%b latency=%0d", d, c, result, inexact, cycles);
        prev_res = er;
        prev_inx = ex;
        start = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        prev_res = '0;
        prev_inx = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        data = '0;
        coefficient = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_inexact", inexact, 0);
        rst_n = 1'b1;

        // Directed vectors.
        do_op(5'b10110, 2'b00, 0);
        do_op(5'b10110, 2'b01, 0);
        do_op(5'b10100, 2'b01, 0);
        do_op(5'b10110, 2'b10, 0);
        do_op(5'b00110, 2'b10, 0);
        do_op(5'b10110, 2'b11, 0);
        // Start held high while busy must be ignored.
        do_op(5'b11111, 2'b01, 1);
        do_op(5'b00000, 2'b11, 0);

        // Reset in the middle of SHIFT.
        @(negedge clk);
        start = 1'b1;
        data = 5'b11111;
        coefficient = 2'b01;
        @(negedge clk);   // the acceptance edge has passed, so this is the first SHIFT cycle
        start = 1'b0;
        check("midshift_busy", busy, 1);
        check("midshift_result", result, 5'b11111);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_result", result, 0);
        check("async_rst_inexact", inexact, 0);
        @(posedge clk);
        @(negedge clk);
        check("rst_hold_busy", busy, 0);
        rst_n = 1'b1;
        prev_res = '0;
        prev_inx = 1'b0;
        do_op(5'b01000, 2'b00, 0);

        // Random operations. Inputs are noisy while busy.
        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), 2'($urandom), 2);
        end

        @(negedge clk);
        check("final_idle", busy, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
